pc_run_monitor: RTL and testbench

//  Synthesisable run monitor for the MIPS core. Watches pc/pcnext/instr every cycle and replaces the

---
 rtl/mips_mon_pkg.sv | 22 ++
 rtl/pc_trace_buf.sv | 46 ++++
 rtl/pc_run_monitor.sv | 122 ++++++++++++
 tb/tb_pc_run_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mon_pkg.sv
// Shared definitions for the MIPS run monitor: status codes and their width.
package mips_mon_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_W-1:0] ST_RUN      = 3'd1;
    localparam logic [ST_W-1:0] ST_PASS     = 3'd2;
    localparam logic [ST_W-1:0] ST_MISMATCH = 3'd3;
    localparam logic [ST_W-1:0] ST_TIMEOUT  = 3'd4;
    localparam logic [ST_W-1:0] ST_HANG     = 3'd5;

    typedef enum logic [ST_W-1:0] {
        MON_IDLE     = ST_IDLE,
        MON_RUN      = ST_RUN,
        MON_PASS     = ST_PASS,
        MON_MISMATCH = ST_MISMATCH,
        MON_TIMEOUT  = ST_TIMEOUT,
        MON_HANG     = ST_HANG
    } mon_state_e;

endpackage

// File: rtl/pc_trace_buf.sv
// Circular buffer of the most recent (pc, instr) pairs; index 0 reads the newest entry.
module pc_trace_buf #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [XLEN-1:0]          wpc,
    input  logic [XLEN-1:0]          winstr,
    input  logic [$clog2(DEPTH)-1:0] idx,
    output logic [XLEN-1:0]          rpc,
    output logic [XLEN-1:0]          rinstr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0]  mem_pc    [DEPTH];
    logic [XLEN-1:0]  mem_instr [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_slot;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            valid  <= '0;
        end else if (we) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + IDX_W'(1);
        end
    end

    // Storage needs no reset: the valid bits mask entries not yet written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_pc[wr_ptr]    <= wpc;
            mem_instr[wr_ptr] <= winstr;
        end
    end

    assign rd_slot = wr_ptr - IDX_W'(1) - idx;
    assign rpc     = valid[rd_slot] ? mem_pc[rd_slot]    : '0;
    assign rinstr  = valid[rd_slot] ? mem_instr[rd_slot] : '0;

endmodule

// File: rtl/pc_run_monitor.sv
// Run monitor for the MIPS core: PASS / MISMATCH / TIMEOUT / HANG detection with sticky status.
// Optional (pc, instr) trace buffer enabled by defining PC_MON_TRACE_EN.
module pc_run_monitor
    import mips_mon_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] PASS_PC     = XLEN'(32'h58),
    parameter int unsigned     MAX_CYCLES  = 1000,
    parameter int unsigned     STALL_LIMIT = 16,
    parameter int unsigned     CNT_W       = 16,
    parameter int unsigned     TRACE_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [XLEN-1:0]                pc,
    input  logic [XLEN-1:0]                pcnext,
    input  logic [XLEN-1:0]                instr,
    output logic                           done,
    output logic                           pass,
    output logic [ST_W-1:0]                status,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [XLEN-1:0]                err_pc,
    output logic [XLEN-1:0]                err_exp,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [XLEN-1:0]                trace_pc,
    output logic [XLEN-1:0]                trace_instr
);

    localparam int unsigned        STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    mon_state_e         state;
    logic [XLEN-1:0]    exp_pc;
    logic [STALL_W-1:0] stall_cnt;

    // Checks use the values registered on the previous edge; terminal states freeze everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MON_IDLE;
            status    <= ST_IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            cycle_cnt <= '0;
            err_pc    <= '0;
            err_exp   <= '0;
            exp_pc    <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                MON_IDLE: begin
                    state     <= MON_RUN;
                    status    <= ST_RUN;
                    exp_pc    <= pcnext;
                    cycle_cnt <= CNT_W'(1);
                end
                MON_RUN: begin
                    if (pc == PASS_PC) begin
                        state  <= MON_PASS;
                        status <= ST_PASS;
                        done   <= 1'b1;
                        pass   <= 1'b1;
                    end else if (pc != exp_pc) begin
                        state   <= MON_MISMATCH;
                        status  <= ST_MISMATCH;
                        done    <= 1'b1;
                        err_pc  <= pc;
                        err_exp <= exp_pc;
                    end else if (cycle_cnt == CNT_LAST) begin
                        state   <= MON_TIMEOUT;
                        status  <= ST_TIMEOUT;
                        done    <= 1'b1;
                        err_pc  <= pc;
                        err_exp <= exp_pc;
                    end else if (stall_cnt == STALL_LAST && pcnext == pc) begin
                        state   <= MON_HANG;
                        status  <= ST_HANG;
                        done    <= 1'b1;
                        err_pc  <= pc;
                        err_exp <= exp_pc;
                    end else begin
                        if (cycle_cnt != '1) begin
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end
                        exp_pc    <= pcnext;
                        stall_cnt <= (pcnext == pc) ? stall_cnt + STALL_W'(1) : '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PC_MON_TRACE_EN
    logic trace_we_c;

    // Includes the terminal-transition edge, since the state is still RUN there.
    assign trace_we_c = (state == MON_RUN);

    pc_trace_buf #(
        .XLEN  (XLEN),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk    (clk),
        .reset  (reset),
        .we     (trace_we_c),
        .wpc    (pc),
        .winstr (instr),
        .idx    (trace_idx),
        .rpc    (trace_pc),
        .rinstr (trace_instr)
    );
`else
    logic unused_trace;

    assign unused_trace = ^{trace_idx, instr};
    assign trace_pc     = '0;
    assign trace_instr  = '0;
`endif

endmodule

// File: tb/tb_pc_run_monitor.sv
// Self-checking bench for pc_run_monitor: directed and randomized runs against a reference model.
module tb_pc_run_monitor;
    import mips_mon_pkg::*;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned TRACE_DEPTH = 8;
    localparam int unsigned MAX_CYCLES  = 40;
    localparam int unsigned STALL_LIMIT = 4;
    localparam logic [31:0] PASS_PC     = 32'h58;
    localparam int          NMAX        = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [XLEN-1:0]  pc = '0, pcnext = '0, instr = '0;
    logic             done, pass;
    logic [ST_W-1:0]  status;
    logic [CNT_W-1:0] cycle_cnt;
    logic [XLEN-1:0]  err_pc, err_exp, trace_pc, trace_instr;
    logic [2:0]       trace_idx = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] pcs   [NMAX];
    logic [31:0] nexts [NMAX];
    logic [31:0] ins   [NMAX];

    always #5 clk = ~clk;

    pc_run_monitor #(
        .XLEN(XLEN), .PASS_PC(PASS_PC), .MAX_CYCLES(MAX_CYCLES),
        .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .pcnext(pcnext), .instr(instr),
        .done(done), .pass(pass), .status(status), .cycle_cnt(cycle_cnt),
        .err_pc(err_pc), .err_exp(err_exp), .trace_idx(trace_idx),
        .trace_pc(trace_pc), .trace_instr(trace_instr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic build_seq(input logic [31:0] start);
        for (int k = 0; k < NMAX; k++) begin
            pcs[k]   = start + 32'(4 * k);
            nexts[k] = pcs[k] + 32'h4;
            ins[k]   = $urandom;
        end
    endtask

    task automatic build_random(input int stall_pct);
        pcs[0] = '0;
        for (int k = 0; k < NMAX; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < stall_pct)   nexts[k] = pcs[k];
            else if (r < 80)     nexts[k] = pcs[k] + 32'h4;
            else                 nexts[k] = 32'($urandom_range(0, 31)) << 2;
            ins[k] = $urandom;
            if (k + 1 < NMAX)
                pcs[k+1] = ($urandom_range(0, 29) == 0) ? nexts[k] + 32'h10 : nexts[k];
        end
    endtask

    // Reference: for each RUN edge k (edge 0 is the IDLE->RUN edge) the expected pc is the
    // pcnext of edge k-1, the cycle count before the edge is k, and the stall run is the number
    // of consecutive pcnext==pc edges immediately preceding k.
    task automatic run_scenario(input string name, input int n);
        bit          term;
        int          last_wr, mcnt, stall;
        logic [2:0]  mstat;
        logic [31:0] mep, mee, expc, ep, ei;

        reset = 1'b1;
        trace_idx = '0;
        @(posedge clk); #1;
        check({name, ".rst_status"}, 32'(status), 32'(ST_IDLE));
        check({name, ".rst_done"}, 32'(done), 32'd0);
        check({name, ".rst_pass"}, 32'(pass), 32'd0);
        check({name, ".rst_cnt"}, 32'(cycle_cnt), 32'd0);
        check({name, ".rst_err_pc"}, err_pc, 32'd0);
        check({name, ".rst_err_exp"}, err_exp, 32'd0);
        reset = 1'b0;

        term = 0; last_wr = 0; mcnt = 0; mstat = ST_IDLE; mep = '0; mee = '0;
        for (int k = 0; k < n; k++) begin
            pc = pcs[k]; pcnext = nexts[k]; instr = ins[k];
            @(posedge clk); #1;
            if (k == 0) begin
                mstat = ST_RUN; mcnt = 1;
            end else if (!term) begin
                last_wr = k;
                expc = nexts[k-1];
                stall = 0;
                for (int j = k - 1; j >= 1; j--) begin
                    if (nexts[j] == pcs[j]) stall++;
                    else break;
                end
                if (pcs[k] == PASS_PC) begin
                    mstat = ST_PASS; term = 1;
                end else if (pcs[k] != expc) begin
                    mstat = ST_MISMATCH; term = 1; mep = pcs[k]; mee = expc;
                end else if (k == int'(MAX_CYCLES) - 1) begin
                    mstat = ST_TIMEOUT; term = 1; mep = pcs[k]; mee = expc;
                end else if (stall == int'(STALL_LIMIT) - 1 && nexts[k] == pcs[k]) begin
                    mstat = ST_HANG; term = 1; mep = pcs[k]; mee = expc;
                end else begin
                    mcnt = k + 1;
                end
            end
            check($sformatf("%s.status@%0d", name, k), 32'(status), 32'(mstat));
            check($sformatf("%s.done@%0d", name, k), 32'(done), 32'(term));
            check($sformatf("%s.pass@%0d", name, k), 32'(pass), 32'(mstat == ST_PASS));
            check($sformatf("%s.cnt@%0d", name, k), 32'(cycle_cnt), 32'(mcnt));
            check($sformatf("%s.err_pc@%0d", name, k), err_pc, mep);
            check($sformatf("%s.err_exp@%0d", name, k), err_exp, mee);
        end

        for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
            trace_idx = 3'(i);
            #1;
`ifdef PC_MON_TRACE_EN
            ep = (last_wr - i >= 1) ? pcs[last_wr - i] : '0;
            ei = (last_wr - i >= 1) ? ins[last_wr - i] : '0;
`else
            ep = '0;
            ei = '0;
`endif
            check($sformatf("%s.trace_pc[%0d]", name, i), trace_pc, ep);
            check($sformatf("%s.trace_instr[%0d]", name, i), trace_instr, ei);
        end
        trace_idx = '0;
    endtask

    initial begin
        // Sequential run reaching PASS_PC at the 23rd edge.
        build_seq(32'h0);
        run_scenario("seq_pass", 30);
        check("seq_pass.final_status", 32'(status), 32'(ST_PASS));
        check("seq_pass.final_cnt", 32'(cycle_cnt), 32'd22);
        check("seq_pass.final_err_pc", err_pc, 32'd0);
`ifdef PC_MON_TRACE_EN
        trace_idx = 3'd7; #1;
        check("seq_pass.trace7", trace_pc, 32'h3c);
        trace_idx = 3'd0; #1;
        check("seq_pass.trace0", trace_pc, 32'h58);
`endif

        // pcnext forced back to 0x40 while the core moves on to 0x44.
        build_seq(32'h0);
        nexts[16] = 32'h40;
        run_scenario("mismatch", 24);
        check("mismatch.final_status", 32'(status), 32'(ST_MISMATCH));
        check("mismatch.final_err_pc", err_pc, 32'h44);
        check("mismatch.final_err_exp", err_exp, 32'h40);

        // Never reaches PASS_PC.
        build_seq(32'h100);
        run_scenario("timeout", 45);
        check("timeout.final_status", 32'(status), 32'(ST_TIMEOUT));
        check("timeout.final_cnt", 32'(cycle_cnt), 32'(MAX_CYCLES - 1));

        // Self-loop at 0x20.
        for (int k = 0; k < NMAX; k++) begin
            pcs[k] = 32'h20; nexts[k] = 32'h20; ins[k] = $urandom;
        end
        run_scenario("hang", 8);
        check("hang.final_status", 32'(status), 32'(ST_HANG));
        check("hang.final_err_pc", err_pc, 32'h20);

        // PASS_PC reached on a pc that also mismatches: PASS wins.
        build_seq(32'h0);
        pcs[1] = 32'h58; nexts[1] = 32'h5c;
        run_scenario("priority", 6);
        check("priority.final_status", 32'(status), 32'(ST_PASS));
        check("priority.final_err_exp", err_exp, 32'd0);

        // Partial run left in RUN; the next scenario's reset must return to IDLE.
        build_seq(32'h200);
        run_scenario("partial", 10);

        for (int s = 0; s < 12; s++) begin
            build_random((s % 3 == 0) ? 45 : 10);
            run_scenario($sformatf("rand%0d", s), 48);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
